// File: rtl/w_pack.sv
// rtl/w_pack.sv - weight packer: assembles precision-dependent beats into 32-bit buffer words
// Slot 0 lands in the LSBs, mirroring the weight read mux on the other side of the buffer.
module w_pack (
   input  logic        clk,
   input  logic        nRST,
   input  logic [2:0]  input_bitwidth,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        in_ready,
   input  logic        flush,
   input  logic        wr_full,
   output logic        wr_en,
   output logic [31:0] wr_data,
   output logic        wr_zero,
   output logic [15:0] zero_cnt,
   output logic        cfg_err
);

   localparam logic [2:0] MODE_2B = 3'b001;
   localparam logic [2:0] MODE_4B = 3'b010;
   localparam logic [2:0] MODE_8B = 3'b100;

   logic [31:0] asm_q, asm_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [2:0]  mode_q, mode_d;
   logic [31:0] out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;
   logic [15:0] zero_cnt_q, zero_cnt_d;
   logic        cfg_err_q, cfg_err_d;

   logic        accept;
   logic [2:0]  eff_mode;
   logic        mode_ok;
   logic        beat_ok;
   logic        bad_beat;
   logic        last_slot;
   logic        flush_go;
   logic        complete;
   logic [31:0] merged;

   // Write side depends only on the output register and wr_full.
   always_comb begin
      in_ready = !out_valid_q || !wr_full;
      wr_en    = out_valid_q && !wr_full;
      wr_data  = out_data_q;
      wr_zero  = wr_en && (out_data_q == 32'd0);
      zero_cnt = zero_cnt_q;
      cfg_err  = cfg_err_q;
   end

   always_comb begin
      accept   = in_valid && in_ready;
      eff_mode = (ptr_q == 2'd0) ? input_bitwidth : mode_q;
      case (eff_mode)
         MODE_2B, MODE_4B, MODE_8B: mode_ok = 1'b1;
         default:                   mode_ok = 1'b0;
      endcase
      beat_ok  = accept && mode_ok;
      bad_beat = accept && !mode_ok;

      merged    = asm_q;
      last_slot = 1'b0;
      if (beat_ok) begin
         case (eff_mode)
            MODE_8B: begin
               case (ptr_q)
                  2'd0: merged[7:0]   = in_data[7:0];
                  2'd1: merged[15:8]  = in_data[7:0];
                  2'd2: merged[23:16] = in_data[7:0];
                  default: merged[31:24] = in_data[7:0];
               endcase
               last_slot = (ptr_q == 2'd3);
            end
            MODE_4B: begin
               if (ptr_q[0]) merged[31:16] = in_data[15:0];
               else          merged[15:0]  = in_data[15:0];
               last_slot = ptr_q[0];
            end
            default: begin
               merged    = in_data;
               last_slot = 1'b1;
            end
         endcase
      end

      // Flush with an empty assembly and no beat has nothing to emit.
      flush_go = flush && in_ready && ((ptr_q != 2'd0) || beat_ok);
      complete = (beat_ok && last_slot) || flush_go;
   end

   always_comb begin
      asm_d       = asm_q;
      ptr_d       = ptr_q;
      mode_d      = mode_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q && !wr_en;
      zero_cnt_d  = zero_cnt_q;
      cfg_err_d   = cfg_err_q || bad_beat;

      if (beat_ok && (ptr_q == 2'd0))
         mode_d = eff_mode;

      if (complete) begin
         out_data_d  = merged;
         out_valid_d = 1'b1;
         asm_d       = 32'd0;
         ptr_d       = 2'd0;
      end else if (beat_ok) begin
         asm_d = merged;
         ptr_d = ptr_q + 2'd1;
      end

      if (wr_zero && (zero_cnt_q != 16'hFFFF))
         zero_cnt_d = zero_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         asm_q       <= 32'd0;
         ptr_q       <= 2'd0;
         mode_q      <= MODE_8B;
         out_data_q  <= 32'd0;
         out_valid_q <= 1'b0;
         zero_cnt_q  <= 16'd0;
         cfg_err_q   <= 1'b0;
      end else begin
         asm_q       <= asm_d;
         ptr_q       <= ptr_d;
         mode_q      <= mode_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         zero_cnt_q  <= zero_cnt_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

endmodule
